// File: rtl/spi_mstr16.sv
// spi_mstr16: 16-bit SPI master, SCLK idles high, MOSI changes on fall, MISO sampled on rise.
// Optional SPI_MSTR_WRT_QUEUE_EN adds a 1-deep pending command launched after completion.
module spi_mstr16 #(
    parameter int SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int CW = $clog2(SCLK_DIV);
    localparam logic [CW-1:0] LOAD_CNT = CW'(3 * SCLK_DIV / 4 - 1);
    localparam logic [CW-1:0] RISE_CNT = CW'(SCLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FALL_CNT = CW'(SCLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        FRONT,
        SHIFT,
        BACK
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] div_cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [15:0]   shift_q;
    logic          smpl_q;
    logic          done_q;
    logic          ss_n_q;
    logic [15:0]   rd_data_q;

    logic          rise_pt;
    logic          fall_pt;
    logic          start;
    logic          load;
    logic          smpl_en;
    logic          shft_en;
    logic          finish;
    logic [15:0]   launch_cmd;

    assign rise_pt = (div_cnt_q == RISE_CNT);
    assign fall_pt = (div_cnt_q == FALL_CNT);

`ifdef SPI_MSTR_WRT_QUEUE_EN
    logic          pend_vld_q;
    logic [15:0]   pend_q;

    assign start      = wrt || pend_vld_q;
    assign launch_cmd = pend_vld_q ? pend_q : cmd;

    // A wrt landing on the launch edge of a pending word becomes the new pending word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld_q <= 1'b0;
            pend_q     <= '0;
        end else if (load && pend_vld_q) begin
            pend_vld_q <= wrt;
            if (wrt) pend_q <= cmd;
        end else if (wrt && state_q != IDLE) begin
            pend_vld_q <= 1'b1;
            pend_q     <= cmd;
        end
    end
`else
    assign start      = wrt;
    assign launch_cmd = cmd;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = FRONT;
            FRONT: if (fall_pt) state_d = SHIFT;
            SHIFT: if (rise_pt && bit_cnt_q == 4'd15) state_d = BACK;
            BACK:  if (fall_pt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load    = 1'b0;
        smpl_en = 1'b0;
        shft_en = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            IDLE:  load = start;
            FRONT: ;
            SHIFT: begin
                smpl_en = rise_pt;
                shft_en = fall_pt;
            end
            BACK: begin
                shft_en = fall_pt;
                finish  = fall_pt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            smpl_q    <= 1'b0;
            done_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            rd_data_q <= '0;
        end else begin
            if (load) begin
                shift_q   <= launch_cmd;
                div_cnt_q <= LOAD_CNT;
                bit_cnt_q <= '0;
                done_q    <= 1'b0;
                ss_n_q    <= 1'b0;
            end else if (state_q != IDLE) begin
                div_cnt_q <= div_cnt_q + CW'(1);
            end
            if (smpl_en) begin
                smpl_q    <= MISO;
                bit_cnt_q <= bit_cnt_q + 4'd1;
            end
            if (shft_en) shift_q <= {shift_q[14:0], smpl_q};
            if (finish) begin
                rd_data_q <= {shift_q[14:0], smpl_q};
                ss_n_q    <= 1'b1;
                done_q    <= 1'b1;
            end
        end
    end

    // The completing fall point also returns to IDLE, so SCLK never drops there
    assign SCLK    = (state_q == IDLE) ? 1'b1 : div_cnt_q[CW-1];
    assign MOSI    = shift_q[15];
    assign SS_n    = ss_n_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;

endmodule
